// File: rtl/main_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : main_fsm
//  Description : Multicycle control sequencer for the RV32I core. Steps the
//                shared datapath through fetch/decode/execute/memory/
//                writeback and stalls on a memory ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module main_fsm #(
    parameter int MEM_WAIT_EN = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       instr_retired,
    output logic       trap,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_ILLEGAL  = 4'd15
    } state_t;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

    state_t r_state;
    state_t w_next;

    logic w_ready_eff;
    logic w_ir_write;
    logic w_pc_update;
    logic w_branch;
    logic w_reg_write;
    logic w_mem_write;

    // With wait states disabled the memory is treated as always ready
    assign w_ready_eff = mem_ready | (MEM_WAIT_EN == 0);

    // State register: reset returns to FETCH from anywhere, including ILLEGAL
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore-decoded datapath controls
    always_comb begin
        w_next        = r_state;
        ALUOp         = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ResultSrc     = 2'b00;
        AdrSrc        = 1'b0;
        w_ir_write    = 1'b0;
        w_pc_update   = 1'b0;
        w_branch      = 1'b0;
        w_reg_write   = 1'b0;
        w_mem_write   = 1'b0;
        instr_retired = 1'b0;

        case (r_state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (w_ready_eff) begin
                    w_ir_write  = 1'b1;
                    w_pc_update = 1'b1;
                    w_next      = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute OldPC+imm as a branch/jump target
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    c_OP_LOAD,
                    c_OP_STORE:  w_next = S_MEMADR;
                    c_OP_RTYPE:  w_next = S_EXECR;
                    c_OP_ITYPE:  w_next = S_EXECI;
                    c_OP_BRANCH: w_next = S_BRANCH;
                    c_OP_JAL:    w_next = S_JAL;
                    c_OP_JALR:   w_next = S_JALR;
                    c_OP_LUI:    w_next = S_LUI;
                    c_OP_AUIPC:  w_next = S_ALUWB;
                    default:     w_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (w_ready_eff) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                w_reg_write   = 1'b1;
                instr_retired = 1'b1;
                w_next        = S_FETCH;
            end
            S_MEMWRITE: begin
                // The write strobe is held for every wait cycle of the access
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
                if (w_ready_eff) begin
                    instr_retired = 1'b1;
                    w_next        = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                w_next  = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                w_next  = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 2'b11;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write   = 1'b1;
                instr_retired = 1'b1;
                w_next        = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA       = 2'b10;
                ALUOp         = 2'b01;
                w_branch      = 1'b1;
                instr_retired = 1'b1;
                w_next        = S_FETCH;
            end
            S_JALR: begin
                // ALUOut = rs1+imm becomes the jump target loaded in JAL
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = S_JAL;
            end
            S_JAL: begin
                // PC takes the held target while the ALU forms OldPC+4 for rd
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                w_pc_update = 1'b1;
                w_next      = S_ALUWB;
            end
            S_ILLEGAL: begin
                w_next = S_ILLEGAL;
            end
            default: begin
                w_next = S_ILLEGAL;
            end
        endcase
    end

    // Write strobes are suppressed combinationally while reset is held
    assign IRWrite  = w_ir_write & ~reset;
    assign PCWrite  = (w_pc_update | (w_branch & branch_taken)) & ~reset;
    assign RegWrite = w_reg_write & ~reset;
    assign MemWrite = w_mem_write & ~reset;

    // ILLEGAL is only left through reset, so the state itself holds the trap
    assign trap  = (r_state == S_ILLEGAL);
    assign state = r_state;

endmodule
`default_nettype wire

// File: doc/main_fsm.md
# main_fsm

Multicycle control sequencer for the RV32I core. Decodes the opcode and steps the shared datapath (single ALU, single memory port, instruction/data registers) through fetch, decode, execute, memory and writeback. Drives `ALUOp` into `alu_dec`, plus the mux selects and write strobes. Memory accesses use a ready handshake so wait-state memories stall the sequence.

## Interface

**Parameters**
- `MEM_WAIT_EN`, default 1: 1 means `mem_ready` gates memory states; 0 means `mem_ready` is ignored and treated as 1.

**Ports**
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `op`, input, 7: `Instr[6:0]` from the instruction register.
- `branch_taken`, input, 1: datapath-evaluated branch condition for the current `funct3`.
- `mem_ready`, input, 1: memory has completed the current access this cycle.
- `ALUOp`, output, 2: to `alu_dec`. 00 add, 01 sub, 10 funct-decoded, 11 lui.
- `ALUSrcA`, output, 2: 00 PC, 01 OldPC, 10 RD1.
- `ALUSrcB`, output, 2: 00 RD2, 01 ImmExt, 10 constant 4.
- `ResultSrc`, output, 2: 00 ALUOut, 01 Data, 10 ALUResult.
- `AdrSrc`, output, 1: 0 PC, 1 Result.
- `IRWrite`, `PCWrite`, `RegWrite`, `MemWrite`, output, 1 each: write strobes.
- `instr_retired`, output, 1: one-cycle pulse on the last cycle of each instruction.
- `trap`, output, 1: illegal opcode seen; sticky.
- `state`, output, 4: current state encoding, for debug.

## Operation

**State encoding:** FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, LUI=12, ILLEGAL=15.

**Output defaults.** Outputs are Moore-decoded from `state`. Every selector not listed below is 00/0, and every strobe is 0.

**Derived signals**
- `PCUpdate` (internal) is asserted only in FETCH and JAL.
- `PCWrite = PCUpdate | (Branch & branch_taken)`. `Branch` is internal and asserted only in BRANCH.
- `ready_eff = mem_ready | ~MEM_WAIT_EN`.

**Per-state behaviour**
- **FETCH:** AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite and PCUpdate are asserted only when `ready_eff`.
  - Go to DECODE when `ready_eff`; otherwise stay.
- **DECODE:** ALUSrcA=01, ALUSrcB=01, ALUOp=00, so ALUOut = OldPC+imm. Next state by `op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 (auipc) → ALUWB
  - any other → ILLEGAL
- **MEMADR:** ALUSrcA=10, ALUSrcB=01, ALUOp=00. Go to MEMREAD if `op[5]`=0, else MEMWRITE.
- **MEMREAD:** AdrSrc=1, ResultSrc=00. Hold until `ready_eff`, then go to MEMWB.
- **MEMWB:** ResultSrc=01, RegWrite=1. Go to FETCH.
- **MEMWRITE:** AdrSrc=1, ResultSrc=00, MemWrite=1.
  - MemWrite stays high every cycle until `ready_eff`; then go to FETCH.
- **EXECR:** ALUSrcA=10, ALUSrcB=00, ALUOp=10. Go to ALUWB.
- **EXECI:** ALUSrcA=10, ALUSrcB=01, ALUOp=10. Go to ALUWB.
- **LUI:** ALUSrcB=01, ALUOp=11. Go to ALUWB.
- **ALUWB:** ResultSrc=00, RegWrite=1. Go to FETCH.
- **BRANCH:** ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00. Go to FETCH.
- **JALR:** ALUSrcA=10, ALUSrcB=01, ALUOp=00, so ALUOut = rs1+imm. Go to JAL.
- **JAL:** ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Go to ALUWB, which writes OldPC+4 to rd.
- **ILLEGAL:** all strobes 0, `trap`=1. Stays in ILLEGAL until `reset`.

**Retire pulse.** `instr_retired`=1 in MEMWB, ALUWB, BRANCH, and in MEMWRITE when `ready_eff`.

## Timing

**Reset**
- `reset` high at an edge loads FETCH and clears `trap`.
- While `reset` is high, IRWrite, PCWrite, RegWrite and MemWrite are forced to 0 combinationally.
- Reset wins over every transition, including mid-MEMWRITE and ILLEGAL.
- After reset, `state`=0 and `trap`=0.

**Latency** (cycles with `mem_ready`=1 throughout)

| Instruction | Cycles |
|---|---|
| lw | 5 |
| jalr | 5 |
| sw | 4 |
| R-type | 4 |
| I-type ALU | 4 |
| lui | 4 |
| jal | 4 |
| auipc | 3 |
| branch | 3 |

- Each cycle that FETCH, MEMREAD or MEMWRITE is stalled (`mem_ready`=0) adds one cycle.

**Handshake timing**
- `mem_ready` is sampled in the same cycle as the access.
- IRWrite and PCWrite pulse exactly once per fetch, in the `ready_eff` cycle.
- A `mem_ready` pulse outside FETCH, MEMREAD and MEMWRITE is ignored.

**Branch timing**
- `branch_taken` is sampled only in BRANCH.
- PCWrite is combinational from it in that same cycle.

## Test plan

- **Reset and R-type.** Assert `reset` for 2 cycles, then `op`=0110011 with `mem_ready`=1.
  - Expect `state` 0,1,6,8,0 and `ALUOp` 00,00,10,xx.
  - Expect `RegWrite`=1 only in the 4th cycle, and `instr_retired` there.
- **lw with wait states.** `op`=0000011, `mem_ready` low for 2 cycles in MEMREAD.
  - Expect states 0,1,2,3,3,3,4,0 (8 cycles total).
  - Expect `AdrSrc`=1 in MEMREAD and `ResultSrc`=01 with RegWrite in MEMWB.
- **Branch taken and not taken.** `op`=1100011 with `branch_taken`=1, then a second run with `branch_taken`=0.
  - Expect `ALUOp`=01 in BRANCH.
  - Expect `PCWrite`=1 in BRANCH for the first run and 0 for the second; 3 cycles each.
- **Jumps.** jal, then jalr.
  - jal: states 0,1,10,8.
  - jalr: states 0,1,11,10,8.
  - Expect `PCWrite` in JAL and `ResultSrc`=00 there; lui goes 0,1,12,8 with `ALUOp`=11.
- **Illegal opcode and reset mid-store.** `op`=1111111.
  - Expect ILLEGAL (15) with `trap`=1 sticky for 10 cycles and no strobes.
  - Then assert `reset` during MEMWRITE with `mem_ready`=0: expect MemWrite=0 that cycle and `state`=0 next.
- **`MEM_WAIT_EN`=0.** Hold `mem_ready`=0 and run sw.
  - Expect states 0,1,2,5,0 with MemWrite for exactly 1 cycle.
